bus_rr_arbiter: RTL and testbench
=================================

# bus_rr_arbiter

Round-robin arbiter and sequencer that shares one multicycle resource (memory port, register-file write port) among M requesters in the multicycle 16-bit RISC-V processor. It chooses a winner, drives the winner's index on `sel` as the `addr` of the L-bit N-select data multiplexer in front of the resource, and runs a valid/ready handshake with the resource. It pulses a per-requester `ack` when each transfer completes. Optional per-requester lock gives bounded back-to-back bursts.

## Interface
- `M`, default 4: number of requesters; must satisfy 2 ≤ M ≤ 2^N.
- `N`, default 2: width of `sel`, the mux address.
- `MAXB`, default 4: maximum consecutive transfers a locked owner may take (≥1).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, M: level request per requester; held high until its `ack`.
- `lock`, in, M: requester asks to keep ownership after the current transfer.
- `res_ready`, in, 1: resource completes the current transfer this cycle.
- `sel`, out, N: index of the current or last winner; drives the mux `addr`.
- `gnt`, out, M: one-hot grant; all zeros when idle.
- `res_valid`, out, 1: transfer in progress toward the resource.
- `ack`, out, M: one-hot completion strobe, combinational.
- `busy`, out, 1: high in XFER.

## Operation
- **States:** IDLE, XFER. Internal registers:
  - `ptr` (N bits): round-robin start index.
  - `own_vld`: a locked owner is pending.
  - `bcnt`: burst count, wide enough for MAXB-1.
- **Reset (async):** state=IDLE, `sel`=0, `gnt`=0, `res_valid`=0, `busy`=0, `ptr`=0, `own_vld`=0, `bcnt`=0. The output `ack` is 0.
- **IDLE arbitration:**
  - If `own_vld` and `req[sel]`=1, `sel` wins.
  - If `own_vld` and `req[sel]`=0, ownership is released: `own_vld`=0, `bcnt`=0, `ptr`=`sel`+1 mod M. Normal arbitration runs in the same cycle, starting from that new `ptr`.
  - Normal arbitration picks the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, … mod M. Indices ≥ M are never selected.
  - On a winner: next cycle `sel`=winner, `gnt`=onehot(winner), `res_valid`=1, and the state moves to XFER.
  - If no requests, stay in IDLE; `sel` holds its last value.
- **XFER:** `sel`, `gnt` and `res_valid` stay stable until `res_ready`=1. `req` and `lock` changes are ignored, except the sample of `lock[sel]` in the completion cycle.
- **Completion cycle** (XFER and `res_ready`=1):
  - `ack` = `gnt` in that same cycle (combinational).
  - Next cycle: state=IDLE, `gnt`=0, `res_valid`=0.
  - If `lock[sel]`=1 and `bcnt`+1 < MAXB: `own_vld`=1 and `bcnt`=`bcnt`+1.
  - Otherwise: `own_vld`=0, `bcnt`=0, and `ptr`=`sel`+1 mod M.
- **Requester protocol:** a requester lowers `req` on the clock edge that ends its `ack` cycle if it has no further work. The IDLE cycle after completion therefore sees the updated `req`.

## Timing
- `req` is sampled in IDLE cycle t. `gnt`, `sel` and `res_valid` are registered and visible from cycle t+1.
- `res_ready` may be high in the first XFER cycle.
- A transfer's minimum length is 2 cycles (XFER + IDLE), so sustained throughput is at most one transfer per 2 cycles.
- `ack` is asserted only in the completion cycle, never in IDLE, and exactly one bit is set.
- `gnt` is never non-zero in IDLE. `res_valid` is high only when `busy`=1 and `gnt`≠0.
- Under the full request load (`req` all high, `lock`=0, `res_ready`=1), any requester waits at most 2M cycles from `req` to `gnt`.
- If reset is asserted mid-XFER, outputs clear immediately and the in-flight transfer is abandoned without an `ack`.

## Test plan
- Reset: assert `rst_n`=0 in the middle of XFER (`gnt`=0100). Required: `gnt`=0, `res_valid`=0, `sel`=0 and `busy`=0 before the next edge. After release, `req`=0001 produces `gnt`=0001.
- Single request: `req`=0100 at cycle 0, `res_ready`=1. Required: cycle 1 has `sel`=2, `gnt`=0100, `res_valid`=1, `ack`=0100. Cycle 2 has `gnt`=0, state IDLE.
- Fairness: `req`=1111 held, `lock`=0, `res_ready`=1. Required: grant order 0,1,2,3,0,1, each granted on alternate cycles.
- Locked burst: `req`=1111, `lock`=0010, MAXB=4, starting from `ptr`=1. Required: requester 1 gets 4 consecutive grants, then requester 2 is granted and `ptr` ends at 3.
- Stall: grant requester 3 and hold `res_ready`=0 for 3 cycles while toggling `req` and `lock[0]`. Required: `sel`=3, `gnt`=1000 and `res_valid`=1 stay stable, and `ack`=1000 appears only when `res_ready` rises.
- Owner release: requester 0 is locked (`bcnt`=1) and drops `req[0]` after its `ack` while `req`=1010. Required: `own_vld` clears and requester 1 is granted next (`ptr`=1).

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one multicycle resource among M requesters,
// with optional bounded lock bursts and a valid/ready handshake toward the resource.
module bus_rr_arbiter #(
  parameter int M    = 4,
  parameter int N    = 2,
  parameter int MAXB = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] req,
  input  logic [M-1:0] lock,
  input  logic         res_ready,
  output logic [N-1:0] sel,
  output logic [M-1:0] gnt,
  output logic         res_valid,
  output logic [M-1:0] ack,
  output logic         busy
);

  localparam int BW = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int NW = N + 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sel_q, sel_d;
  logic [N-1:0]   ptr_q, ptr_d;
  logic [M-1:0]   gnt_q, gnt_d;
  logic           res_valid_q, res_valid_d;
  logic           own_vld_q, own_vld_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;

  logic [N-1:0]   scan_start;
  logic [N-1:0]   win;
  logic           found;
  logic [N:0]     idx;
  logic           owner_gone;

  function automatic logic [N-1:0] inc_mod(input logic [N-1:0] v);
    if (32'(v) >= M - 1) return '0;
    return v + 1'b1;
  endfunction

  // A locked owner whose request vanished releases ownership in the same cycle.
  assign owner_gone = own_vld_q && !req[sel_q];

  always_comb begin
    scan_start = owner_gone ? inc_mod(sel_q) : ptr_q;
    win        = '0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < M; i++) begin
      idx = {1'b0, scan_start} + NW'(i);
      if (32'(idx) >= M) idx = idx - NW'(M);
      if (!found && req[idx[N-1:0]]) begin
        found = 1'b1;
        win   = idx[N-1:0];
      end
    end
    if (own_vld_q && req[sel_q]) begin
      found = 1'b1;
      win   = sel_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    res_valid_d = res_valid_q;
    own_vld_d   = own_vld_q;
    bcnt_d      = bcnt_q;
    case (state_q)
      IDLE: begin
        if (owner_gone) begin
          own_vld_d = 1'b0;
          bcnt_d    = '0;
          ptr_d     = inc_mod(sel_q);
        end
        if (found) begin
          sel_d       = win;
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          res_valid_d = 1'b1;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (res_ready) begin
          state_d     = IDLE;
          gnt_d       = '0;
          res_valid_d = 1'b0;
          if (lock[sel_q] && (32'(bcnt_q) + 32'd1 < 32'(MAXB))) begin
            own_vld_d = 1'b1;
            bcnt_d    = bcnt_q + 1'b1;
          end else begin
            own_vld_d = 1'b0;
            bcnt_d    = '0;
            ptr_d     = inc_mod(sel_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      own_vld_q   <= 1'b0;
      bcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      own_vld_q   <= own_vld_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q == XFER);
  assign ack       = (state_q == XFER && res_ready) ? gnt_q : '0;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: expected winners queued at stimulus time,
// popped and compared whenever the arbiter strobes ack.
module tb_bus_rr_arbiter;

  localparam int M = 4;
  localparam int N = 2;
  localparam int MAXB = 4;

  logic         clk;
  logic         rst_n;
  logic [M-1:0] req;
  logic [M-1:0] lock;
  logic         res_ready;
  logic [N-1:0] sel;
  logic [M-1:0] gnt;
  logic         res_valid;
  logic [M-1:0] ack;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int sb[$];
  int plan[$];

  bus_rr_arbiter #(.M(M), .N(N), .MAXB(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .res_ready(res_ready),
    .sel(sel), .gnt(gnt), .res_valid(res_valid), .ack(ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and idle-state invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack !== '0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_ack", 32'(ack), 32'd0);
        end else begin
          int e;
          e = sb.pop_front();
          chk("sb_ack", 32'(ack), 32'd1 << e);
          $display("ack seen: requester %0d (sel=%0d)", e, sel);
        end
      end
      if (!busy) chk("idle_quiet", {29'd0, gnt != '0, res_valid, ack != '0}, 32'd0);
    end
  end

  // Runs each queued winner: one IDLE cycle, then one XFER cycle that completes.
  task automatic run_plan();
    int k;
    while (plan.size() > 0) begin
      k = plan.pop_front();
      sb.push_back(k);
      @(negedge clk);
      chk("arb_idle_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("xfer_gnt", 32'(gnt), 32'd1 << k);
      chk("xfer_sel", 32'(sel), 32'(k));
      chk("xfer_valid", 32'(res_valid), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request, immediate completion.
    req = 4'b0100; res_ready = 1'b1;
    plan = '{2};
    run_plan();
    req = '0;
    @(negedge clk);
    chk("single_after_gnt", 32'(gnt), 32'd0);
    chk("single_after_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Stall on requester 3 while inputs wiggle.
    req = 4'b1000; res_ready = 1'b0;
    sb.push_back(3);
    @(negedge clk);
    chk("stall_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      req = 4'(s * 5 + 1);
      lock[0] = ~lock[0];
      @(negedge clk);
      chk("stall_sel", 32'(sel), 32'd3);
      chk("stall_gnt", 32'(gnt), 32'b1000);
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_ack", 32'(ack), 32'd0);
      @(posedge clk); #1;
    end
    req = 4'b1000; lock = '0; res_ready = 1'b1;
    @(negedge clk);
    chk("stall_done_ack", 32'(ack), 32'b1000);
    @(posedge clk); #1;
    req = '0;

    // Fairness under full load, ptr starts at 0.
    req = 4'b1111;
    plan = '{0, 1, 2, 3, 0, 1};
    run_plan();
    req = '0;

    // Owner release: requester 0 locked once, then drops its request.
    req = 4'b0001; lock = 4'b0001;
    plan = '{0};
    run_plan();
    req = 4'b1010; lock = '0;
    plan = '{1};
    run_plan();
    req = '0;

    // Move ptr to 1, then a locked burst by requester 1.
    req = 4'b0001;
    plan = '{0};
    run_plan();
    req = 4'b1111; lock = 4'b0010;
    plan = '{1, 1, 1, 1, 2, 3};
    run_plan();
    req = '0; lock = '0;

    // Reset in the middle of a stalled transfer.
    req = 4'b0100; res_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_pre_gnt", 32'(gnt), 32'b0100);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    req = 4'b0001; res_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    plan = '{0};
    run_plan();
    req = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
